bcla_add_arbiter: RTL and testbench

- Shares one 21-bit block carry look-ahead adder core (4/4/4/4/4/1 grouping, explicit carry-in) among N_REQ requesters.
- Round-robin grant; one transaction in flight.
- Each transaction is either a narrow 21+21-bit add or a wide 42+42-bit add. A wide add runs as two sequenced passes through the same core, with the low-pass carry-out fed to the high-pass carry-in.
- Sits between requester-side engines and the shared adder. The result returns on a single tagged response port with backpressure.

---
 rtl/bcla_add_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bcla_add_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcla_add_arbiter.sv
// Round-robin arbiter sharing one 21-bit block carry look-ahead adder among N_REQ requesters.
// Narrow adds take one pass; wide 42-bit adds take two passes with the carry chained between them.

module bcla21_core (
  input  logic [20:0] a,
  input  logic [20:0] b,
  input  logic        cin,
  output logic [20:0] sum,
  output logic        cout
);

  localparam int W  = 21;
  localparam int GW = 4;
  localparam int NG = 6;  // five 4-bit groups plus a 1-bit top group

  logic [W-1:0]  p;
  logic [W-1:0]  g;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG:0]   grp_c;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : group_pg
    p     = a ^ b;
    g     = a & b;
    grp_p = '1;
    grp_g = '0;
    for (int i = 0; i < W; i++) begin
      grp_g[i/GW] = g[i] | (p[i] & grp_g[i/GW]);
      grp_p[i/GW] = grp_p[i/GW] & p[i];
    end
  end

  // Second-level look-ahead: each group carry is a flat sum of products of group terms.
  always_comb begin : group_carry
    logic term;
    logic acc;
    grp_c    = '0;
    grp_c[0] = cin;
    term     = 1'b0;
    acc      = 1'b0;
    for (int k = 1; k <= NG; k++) begin
      acc = cin;
      for (int j = 0; j < k; j++) acc = acc & grp_p[j];
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  always_comb begin : bit_sum
    logic rc;
    sum = '0;
    rc  = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i % GW == 0) rc = grp_c[i/GW];
      sum[i] = p[i] ^ rc;
      rc     = g[i] | (p[i] & rc);
    end
  end

  assign cout = grp_c[NG];

endmodule

module bcla_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_wide,
  input  logic [N_REQ*42-1:0] req_x,
  input  logic [N_REQ*42-1:0] req_y,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_wide,
  output logic [42:0]        resp_sum,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            found;

  logic [41:0]     x_q;
  logic [41:0]     y_q;
  logic            wide_q;
  logic            carry_q;
  logic [20:0]     sum_lo_q;

  logic [20:0]     core_a;
  logic [20:0]     core_b;
  logic            core_cin;
  logic [20:0]     core_sum;
  logic            core_cout;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin : rr_search
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = LO;
      LO:      state_next = wide_q ? HI : RESP;
      HI:      state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign req_ready  = (!rst && state == IDLE && found) ? (N_REQ'(1) << grant) : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Single core: the high pass takes the upper operand halves and the stored low-pass carry.
  assign core_a   = (state == HI) ? x_q[41:21] : x_q[20:0];
  assign core_b   = (state == HI) ? y_q[41:21] : y_q[20:0];
  assign core_cin = (state == HI) ? carry_q : 1'b0;

  bcla21_core u_core (
    .a    (core_a),
    .b    (core_b),
    .cin  (core_cin),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wide_q    <= 1'b0;
      carry_q   <= 1'b0;
      sum_lo_q  <= '0;
      resp_id   <= '0;
      resp_wide <= 1'b0;
      resp_sum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_q       <= req_x[int'(grant)*42 +: 42];
            y_q       <= req_y[int'(grant)*42 +: 42];
            wide_q    <= req_wide[grant];
            resp_wide <= req_wide[grant];
            resp_id   <= grant;
            rr_ptr    <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
          end
        end
        LO: begin
          sum_lo_q <= core_sum;
          carry_q  <= core_cout;
          if (!wide_q) resp_sum <= {21'b0, core_cout, core_sum};
        end
        HI: begin
          resp_sum <= {core_cout, core_sum, sum_lo_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcla_add_arbiter.sv
// Directed self-checking bench for bcla_add_arbiter: latency, carry chaining,
// round-robin order, backpressure and mid-transaction reset.

module tb_bcla_add_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_wide;
  logic [N_REQ*42-1:0] req_x;
  logic [N_REQ*42-1:0] req_y;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic                resp_wide;
  logic [42:0]         resp_sum;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;

  bcla_add_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wide   (req_wide),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_wide  (resp_wide),
    .resp_sum   (resp_sum),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction from requester idx with resp_ready held high.
  task automatic run_txn(input int idx, input logic wide, input logic [41:0] x,
                         input logic [41:0] y, input logic [42:0] exp_sum, input string tag);
    int lat;
    req_valid           = '0;
    req_valid[idx]      = 1'b1;
    req_wide[idx]       = wide;
    req_x[idx*42 +: 42] = x;
    req_y[idx*42 +: 42] = y;
    resp_ready          = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(req_ready), 64'(1) << idx);
    tick();
    req_valid           = '0;
    req_x[idx*42 +: 42] = '1;
    req_y[idx*42 +: 42] = '1;
    check({tag, "_ready_drop"}, 64'(req_ready), 64'd0);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), wide ? 64'd3 : 64'd2);
    check({tag, "_id"}, 64'(resp_id), 64'(idx));
    check({tag, "_wide"}, 64'(resp_wide), 64'(wide));
    check({tag, "_sum"}, 64'(resp_sum), 64'(exp_sum));
    tick();
    check({tag, "_valid_clear"}, 64'(resp_valid), 64'd0);
  endtask

  logic [41:0] tx [N_REQ];
  logic [41:0] ty [N_REQ];
  logic [42:0] tsum [N_REQ];
  logic        twide [N_REQ];

  initial begin
    int ng;
    int nr;
    int lat;

    tx[0] = 42'h0ABCDE;       ty[0] = 42'h154321;       tsum[0] = 43'h1FFFFF;       twide[0] = 1'b0;
    tx[1] = 42'h1FFFFF;       ty[1] = 42'h1FFFFF;       tsum[1] = 43'h3FFFFE;       twide[1] = 1'b0;
    tx[2] = 42'h155_5555_5555; ty[2] = 42'h0AA_AAAA_AAAA; tsum[2] = 43'h1FF_FFFF_FFFF; twide[2] = 1'b1;
    tx[3] = 42'h000_0020_0000; ty[3] = 42'h3FF_FFE0_0000; tsum[3] = 43'h400_0000_0000; twide[3] = 1'b1;

    rst        = 1'b1;
    req_valid  = '0;
    req_wide   = '0;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_resp_sum", 64'(resp_sum), 64'd0);
    check("reset_resp_id", 64'(resp_id), 64'd0);
    check("reset_resp_wide", 64'(resp_wide), 64'd0);
    rst = 1'b0;
    tick();

    run_txn(1, 1'b0, 42'h1FFFFF, 42'h000001, 43'h0200000, "narrow_carry");
    run_txn(0, 1'b1, 42'h000001FFFFF, 42'h00000000001, 43'h00000200000, "wide_xcarry");
    run_txn(0, 1'b1, 42'h3FFFFFFFFFF, 42'h3FFFFFFFFFF, 43'h7FFFFFFFFFE, "wide_ovf");

    // Round-robin from a fresh pointer with every requester continuously valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_x[i*42 +: 42] = tx[i];
      req_y[i*42 +: 42] = ty[i];
      req_wide[i]       = twide[i];
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 200 && nr < 5; cyc++) begin
      if (req_ready != '0) begin
        if (ng < 5) check("rr_grant", 64'(req_ready), 64'(1) << (ng % N_REQ));
        else        check("rr_extra_grant", 64'(req_ready), 64'd0);
        ng++;
      end
      if (resp_valid) begin
        check("rr_resp_id", 64'(resp_id), 64'(nr % N_REQ));
        check("rr_resp_sum", 64'(resp_sum), 64'(tsum[nr % N_REQ]));
        nr++;
        if (nr == 5) req_valid = '0;
      end
      tick();
    end
    check("rr_resp_count", 64'(nr), 64'd5);
    check("rr_grant_count", 64'(ng), 64'd5);

    // Backpressure: pointer now at 1, so requester 1 wins over 2.
    resp_ready = 1'b0;
    req_valid  = 4'b0110;
    #1;
    check("bp_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 64'(resp_valid), 64'd1);
      check("bp_sum_hold", 64'(resp_sum), 64'(tsum[1]));
      check("bp_id_hold", 64'(resp_id), 64'd1);
      check("bp_no_grant", 64'(req_ready), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_valid_before_accept", 64'(resp_valid), 64'd1);
    tick();
    check("bp_valid_after_accept", 64'(resp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("bp_next_latency", 64'(lat), 64'd3);
    check("bp_next_id", 64'(resp_id), 64'd2);
    check("bp_next_sum", 64'(resp_sum), 64'(tsum[2]));
    tick();

    // Reset while the high pass of a wide add is in progress.
    req_valid = 4'b1000;
    #1;
    check("rst_mid_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    check("rst_mid_busy_hi", 64'(busy), 64'd1);
    check("rst_mid_no_valid_hi", 64'(resp_valid), 64'd0);
    rst       = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("rst_mid_ready_gated", 64'(req_ready), 64'd0);
    tick();
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_sum", 64'(resp_sum), 64'd0);
    check("rst_mid_id", 64'(resp_id), 64'd0);
    check("rst_mid_wide", 64'(resp_wide), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd0);
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_no_resp", 64'(resp_valid), 64'd0);
    end
    req_valid = 4'b0110;
    #1;
    check("rst_first_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("rst_first_latency", 64'(lat), 64'd2);
    check("rst_first_id", 64'(resp_id), 64'd1);
    check("rst_first_sum", 64'(resp_sum), 64'(tsum[1]));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
